// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 64;
  localparam int FETCH_INSTR_W = 32;

  localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
    logic                     fault;
    logic                     filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular fetch buffer with alloc/fill/head pointers and occupancy.
// With FETCH_MISALIGN_CHECK_EN the fill pointer skips pre-filled fault entries.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic [FETCH_ADDR_W-1:0]  alloc_pc_i,
  input  logic                     alloc_fault_i,
  input  logic                     fill_i,
  input  logic [FETCH_INSTR_W-1:0] fill_instr_i,
  input  logic                     pop_i,
  output logic [FETCH_ADDR_W-1:0]  head_pc_o,
  output logic [FETCH_INSTR_W-1:0] head_instr_o,
  output logic                     head_fault_o,
  output logic                     head_valid_o,
  output logic [PTR_W-1:0]         count_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  fetch_entry_t     entries_q [DEPTH];
  fetch_entry_t     head_entry;
  logic [PTR_W-1:0] alloc_q, fill_q, head_q, fill_d;

  assign head_entry   = entries_q[head_q[IDX_W-1:0]];
  assign head_pc_o    = head_entry.pc;
  assign head_instr_o = head_entry.instr;
  assign head_fault_o = head_entry.fault;
  assign head_valid_o = (head_q != alloc_q) && head_entry.filled;
  assign count_o      = alloc_q - head_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic [PTR_W-1:0] alloc_next;
  logic [IDX_W-1:0] scan_idx;
  logic             scan_filled;

  // Responses must land on the oldest entry still waiting for memory, so the
  // fill pointer walks past any run of fault entries that were filled at allocation.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    alloc_next  = alloc_q + PTR_W'(alloc_i);
    fill_d      = fill_q + PTR_W'(fill_i);
    scan_idx    = '0;
    scan_filled = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx    = fill_d[IDX_W-1:0];
      scan_filled = (alloc_i && scan_idx == alloc_q[IDX_W-1:0]) ? alloc_fault_i
                                                                 : entries_q[scan_idx].filled;
      if (fill_d != alloc_next && scan_filled) fill_d = fill_d + PTR_ONE;
    end
  end
`else
  assign fill_d = fill_q + PTR_W'(fill_i);
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      // NOTE: storage is reset because decode reads the head entry directly and must see zeros.
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (flush_i) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i].filled <= 1'b0;
    end else begin
      if (alloc_i) begin
        entries_q[alloc_q[IDX_W-1:0]] <= '{pc: alloc_pc_i, instr: '0,
                                           fault: alloc_fault_i, filled: alloc_fault_i};
      end
      if (fill_i) begin
        entries_q[fill_q[IDX_W-1:0]].instr  <= fill_instr_i;
        entries_q[fill_q[IDX_W-1:0]].filled <= 1'b1;
      end
      alloc_q <= alloc_q + PTR_W'(alloc_i);
      fill_q  <= fill_d;
      head_q  <= head_q + PTR_W'(pop_i);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC handshake, in-order instruction memory reads, flush drop counter.
// FETCH_MISALIGN_CHECK_EN turns misaligned PCs into fault entries without a memory read.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int DEPTH   = 4,
  parameter int INSTR_W = FETCH_INSTR_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [ADDR_W-1:0]  PCIn,
  input  logic               PCValid,
  output logic               PCReady,
  output logic [ADDR_W-1:0]  MemReqAddr,
  output logic               MemReqValid,
  input  logic               MemReqReady,
  input  logic [INSTR_W-1:0] MemRspData,
  input  logic               MemRspValid,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrFault,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               Flush
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [PTR_W-1:0]  drop_q, drop_d;
  logic [PTR_W-1:0]  inflight_q, inflight_d;
  logic [PTR_W-1:0]  count;
  logic [SUM_W-1:0]  occ_sum;
  logic              accept, misalign, req_hs, fill, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = (PCIn[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Dropped reads still occupy memory slots, so they count against the buffer depth.
  assign occ_sum = {1'b0, count} + {1'b0, drop_q};
  assign PCReady = !Rst && !Flush && (occ_sum < DEPTH_S) && (!mem_req_valid_q || MemReqReady);
  assign accept  = PCValid && PCReady;
  assign req_hs  = mem_req_valid_q && MemReqReady;
  assign fill    = MemRspValid && (drop_q == '0) && !Flush;
  assign pop     = InstrValid && InstrReady && !Flush;

  assign MemReqValid = mem_req_valid_q;
  assign MemReqAddr  = mem_req_addr_q;

  always_comb begin
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    if (Flush) begin
      mem_req_valid_d = 1'b0;
    end else if (accept && !misalign) begin
      mem_req_valid_d = 1'b1;
      mem_req_addr_d  = {PCIn[ADDR_W-1:2], 2'b00};
    end else if (req_hs) begin
      mem_req_valid_d = 1'b0;
    end

    inflight_d = inflight_q + PTR_W'(req_hs) - PTR_W'(MemRspValid);
    drop_d     = drop_q;
    if (Flush) begin
      drop_d = inflight_d;
    end else if (MemRspValid && drop_q != '0) begin
      drop_d = drop_q - PTR_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      drop_q          <= '0;
      inflight_q      <= '0;
    end else begin
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      drop_q          <= drop_d;
      inflight_q      <= inflight_d;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .Clk          (Clk),
    .Rst          (Rst),
    .flush_i      (Flush),
    .alloc_i      (accept),
    .alloc_pc_i   (PCIn),
    .alloc_fault_i(misalign),
    .fill_i       (fill),
    .fill_instr_i (MemRspData),
    .pop_i        (pop),
    .head_pc_o    (InstrPC),
    .head_instr_o (InstrOut),
    .head_fault_o (InstrFault),
    .head_valid_o (InstrValid),
    .count_o      (count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with an in-order variable-latency memory model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               Clk = 1'b0;
  logic               Rst;
  logic [ADDR_W-1:0]  PCIn;
  logic               PCValid;
  logic               PCReady;
  logic [ADDR_W-1:0]  MemReqAddr;
  logic               MemReqValid;
  logic               MemReqReady;
  logic [INSTR_W-1:0] MemRspData;
  logic               MemRspValid;
  logic [INSTR_W-1:0] InstrOut;
  logic [ADDR_W-1:0]  InstrPC;
  logic               InstrFault;
  logic               InstrValid;
  logic               InstrReady;
  logic               Flush;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
    .Clk(Clk), .Rst(Rst), .PCIn(PCIn), .PCValid(PCValid), .PCReady(PCReady),
    .MemReqAddr(MemReqAddr), .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
    .MemRspData(MemRspData), .MemRspValid(MemRspValid),
    .InstrOut(InstrOut), .InstrPC(InstrPC), .InstrFault(InstrFault),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Flush(Flush)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [63:0] pc; logic [31:0] instr; logic fault; } exp_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   pop_cycles[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   lat       = 1;
  bit   mem_rdy   = 1'b1;
  int   req_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    if (a == 64'h100) return NOP_INSTR;
    return 32'hAAAA_0001 + a[33:2];
  endfunction

  function automatic exp_t expect_for(input logic [63:0] pc);
    exp_t e;
    e.pc = pc;
    if (pc[1:0] != 2'b00) begin
      e.instr = '0;
      e.fault = 1'b1;
    end else begin
      e.instr = mem_data(pc);
      e.fault = 1'b0;
    end
    return e;
  endfunction

  // Memory model: in order, fixed latency per request, no response backpressure.
  initial begin
    MemReqReady = 1'b0;
    MemRspValid = 1'b0;
    MemRspData  = '0;
    forever begin
      @(negedge Clk);
      cyc++;
      MemReqReady = mem_rdy;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        MemRspValid = 1'b1;
        MemRspData  = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else begin
        MemRspValid = 1'b0;
        MemRspData  = '0;
      end
      #1;
      if (Rst) begin
        rsp_q.delete();
        MemRspValid = 1'b0;
      end else if (MemReqValid && MemReqReady) begin
        rsp_q.push_back('{cyc + lat, mem_data(MemReqAddr)});
        req_count++;
      end
    end
  end

  // Monitor: compares every consumed head entry against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (!Rst && !Flush && InstrValid && InstrReady) begin
        pop_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc 0x%0h instr 0x%0h, no entry expected", InstrPC, InstrOut);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", InstrPC, e.pc);
          check("sb_instr", {32'b0, InstrOut}, {32'b0, e.instr});
          check("sb_fault", {63'b0, InstrFault}, {63'b0, e.fault});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send_pc(input logic [63:0] pc);
    int n = 0;
    PCValid = 1'b1;
    PCIn    = pc;
    #1;
    while (!PCReady && n < 50) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check("pc_accept", {63'b0, PCReady}, 64'd1);
    if (PCReady) exp_q.push_back(expect_for(pc));
    @(negedge Clk);
    PCValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("drain_remaining", exp_q.size(), 64'd0);
    repeat (8) @(negedge Clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memreqvalid"}, {63'b0, MemReqValid}, 64'd0);
    check({tag, "_memreqaddr"}, MemReqAddr, 64'd0);
    check({tag, "_instrvalid"}, {63'b0, InstrValid}, 64'd0);
    check({tag, "_instrout"}, {32'b0, InstrOut}, 64'd0);
    check({tag, "_instrpc"}, InstrPC, 64'd0);
    check({tag, "_instrfault"}, {63'b0, InstrFault}, 64'd0);
  endtask

  initial begin
    int n;
    Rst = 1'b1; Flush = 1'b0; PCValid = 1'b0; PCIn = '0; InstrReady = 1'b0;

    // Reset state
    @(negedge Clk);
    #1;
    check("rst_pcready", {63'b0, PCReady}, 64'd0);
    check_reset_outputs("rst");
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // Back-to-back fetch, 1-cycle memory, decode always ready
    lat = 1;
    InstrReady = 1'b1;
    pop_cycles.delete();
    send_pc(64'h0);
    send_pc(64'h4);
    send_pc(64'h8);
    drain();
    check("b2b_pops", pop_cycles.size(), 64'd3);
    if (pop_cycles.size() == 3) begin
      check("b2b_gap01", pop_cycles[1] - pop_cycles[0], 64'd1);
      check("b2b_gap12", pop_cycles[2] - pop_cycles[1], 64'd1);
    end

    // Fill to DEPTH with decode stalled, then a single pop frees one slot
    InstrReady = 1'b0;
    send_pc(64'h10);
    send_pc(64'h14);
    send_pc(64'h18);
    send_pc(64'h1C);
    PCValid = 1'b1;
    PCIn    = 64'h20;
    repeat (3) @(negedge Clk);
    #1;
    check("full_block", {63'b0, PCReady}, 64'd0);
    @(negedge Clk);
    InstrReady = 1'b1;
    #1;
    check("full_pop_cycle", {63'b0, PCReady}, 64'd0);
    @(negedge Clk);
    InstrReady = 1'b0;
    #1;
    check("one_slot", {63'b0, PCReady}, 64'd1);
    if (PCReady) exp_q.push_back(expect_for(64'h20));
    @(negedge Clk);
    PCIn = 64'h24;
    #1;
    check("full_again", {63'b0, PCReady}, 64'd0);
    PCValid = 1'b0;
    @(negedge Clk);
    InstrReady = 1'b1;
    drain();

    // Flush with two reads outstanding at latency 5
    lat = 5;
    send_pc(64'h40);
    send_pc(64'h44);
    Flush = 1'b1;
    exp_q.delete();
    #1;
    check("flush_pcready", {63'b0, PCReady}, 64'd0);
    @(negedge Clk);
    Flush = 1'b0;
    #1;
    check("flush_ivalid", {63'b0, InstrValid}, 64'd0);
    @(negedge Clk);
    send_pc(64'h100);
    drain();

    // Flush coinciding with a response and a valid PC
    lat = 3;
    send_pc(64'h200);
    send_pc(64'h204);
    n = 0;
    do begin
      @(negedge Clk);
      #1;
      n++;
    end while (!MemRspValid && n < 20);
    check("rsp_seen", {63'b0, MemRspValid}, 64'd1);
    Flush   = 1'b1;
    PCValid = 1'b1;
    PCIn    = 64'h300;
    exp_q.delete();
    #1;
    check("flush_rsp_pcready", {63'b0, PCReady}, 64'd0);
    @(negedge Clk);
    Flush   = 1'b0;
    PCValid = 1'b0;
    #1;
    check("flush_rsp_ivalid", {63'b0, InstrValid}, 64'd0);
    @(negedge Clk);
    send_pc(64'h300);
    drain();

    // Request stalled at memory, reset in the second stalled cycle
    lat = 1;
    #1;
    mem_rdy = 1'b0;
    @(negedge Clk);
    send_pc(64'h500);
    #1;
    check("stall1_valid", {63'b0, MemReqValid}, 64'd1);
    check("stall1_addr", MemReqAddr, 64'h500);
    check("stall1_pcready", {63'b0, PCReady}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    exp_q.delete();
    #1;
    check("stall2_valid", {63'b0, MemReqValid}, 64'd1);
    check("stall2_addr", MemReqAddr, 64'h500);
    check("stall2_pcready", {63'b0, PCReady}, 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    mem_rdy = 1'b1;
    @(negedge Clk);
    send_pc(64'h600);
    drain();

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned PC between two aligned ones
    lat = 2;
    req_count = 0;
    send_pc(64'h0);
    send_pc(64'h6);
    send_pc(64'h8);
    drain();
    check("misalign_reqs", req_count, 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Accepts each PC value over a valid/ready handshake and issues a 32-bit instruction read to instruction memory, which has variable latency and returns responses in order.
- Buffers returned instructions with their PC and presents them to decode over a second valid/ready handshake.
- Supports a flush (branch redirect) that discards all buffered and in-flight fetches.

Parameters:
- ADDR_W, 64, PC / memory address width.
- DEPTH, 4, entries in the fetch buffer; also the maximum number of outstanding memory reads (power of 2, at least 2).
- INSTR_W, 32, instruction width.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset; synchronous, active-high.
- PCIn  in  ADDR_W  fetch address from the program counter.
- PCValid  in  1  PCIn valid.
- PCReady  out  1  fetch unit accepts PCIn this cycle.
- MemReqAddr  out  ADDR_W  instruction memory read address.
- MemReqValid  out  1  read request valid.
- MemReqReady  in  1  memory accepts the request.
- MemRspData  in  INSTR_W  returned instruction word.
- MemRspValid  in  1  response valid; no backpressure; in order.
- InstrOut  out  INSTR_W  instruction to decode.
- InstrPC  out  ADDR_W  PC of InstrOut.
- InstrFault  out  1  entry carries a fetch fault (see Optional Feature).
- InstrValid  out  1  head entry is filled and valid.
- InstrReady  in  1  decode consumes the head entry.
- Flush  in  1  discard all buffered and in-flight fetches.

Behaviour:
- **Reset:** Rst high at a rising Clk edge clears everything.
  - Pointers, occupancy and drop count become 0.
  - PCReady=0, MemReqValid=0, InstrValid=0, InstrFault=0, InstrOut=0, InstrPC=0, MemReqAddr=0.
  - Reset mid-operation discards all state; instruction memory shares Rst, so no stale response arrives after reset.
- **Buffer:** circular buffer of DEPTH entries {pc, instr, fault, filled}.
  - Three pointers: alloc, fill, head; pointer width is log2(DEPTH)+1 so full and empty can be distinguished.
  - Wrap-around is modulo DEPTH.
- **Request side:**
  - PCReady = !Flush && occupancy<DEPTH && (!MemReqValid || MemReqReady).
  - On PCValid&&PCReady: allocate an entry (pc=PCIn, filled=0), register MemReqAddr={PCIn[ADDR_W-1:2],2'b00}, and set MemReqValid=1 the next cycle.
  - MemReqValid/MemReqAddr hold stable until MemReqReady.
  - A new PC may be accepted in the same cycle the current request handshakes.
- **Response side:**
  - On MemRspValid with drop count 0: write instr into the entry at the fill pointer, set filled=1, advance fill.
  - On MemRspValid with drop count >0: discard the response and decrement the drop count.
- **Decode side:**
  - InstrValid = head entry allocated && filled; InstrOut/InstrPC/InstrFault come from the head entry (registered storage).
  - Head pops on InstrValid&&InstrReady.
  - Fill latency: a response in cycle N makes InstrValid=1 in N+1.
- **Occupancy:**
  - Occupancy counts allocated, not-yet-popped entries.
  - Full (occupancy==DEPTH): PCReady=0.
  - Empty: InstrValid=0.
  - Allocate and pop in the same cycle leave occupancy unchanged.
- **Flush (highest priority after Rst):**
  - All buffer entries are invalidated and pointers reset to 0.
  - Drop count = requests accepted by memory whose responses are still due, plus the pending request if MemReqValid&&MemReqReady this cycle.
  - A pending request not yet accepted (MemReqValid && !MemReqReady) is withdrawn: MemReqValid=0 next cycle.
  - PCReady=0 in the flush cycle, so no PC is accepted.
  - A MemRspValid in the flush cycle is discarded and reduces the drop count by 1.
  - InstrReady is ignored in the flush cycle; InstrValid=0 the next cycle.
- **Outstanding bound:** total outstanding reads (live plus drop) never exceed DEPTH. PCReady is additionally gated by occupancy+drop<DEPTH.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- **Defined:** an accepted PCIn with PCIn[1:0]!=0 allocates an entry with fault=1, instr=0, filled=1 immediately.
  - No memory request is issued for it.
  - The fill pointer skips the entry so in-order responses still land correctly: the fill pointer advances past any consecutive pre-filled fault entries.
- **Undefined:** PCIn[1:0] is ignored (word-aligned fetch), InstrFault is tied to 0, and no fault logic is generated.

Decomposition:
- Shared package fetch_pkg holds:
  - ADDR_W and INSTR_W defaults.
  - NOP_INSTR constant (32'hD503201F).
  - fetch_entry_t struct {pc, instr, fault, filled}.
- One natural sub-module: fetch_buffer, holding the circular storage, pointers and occupancy.
  - Top level keeps the handshake logic and drop counter.

Test Plan:
- Rst, then PCIn=0x0,0x4,0x8 back-to-back, memory 1-cycle latency with data 0xAAAA0001.. and InstrReady=1 -> InstrOut sequence 0xAAAA0001/2/3 with InstrPC 0x0/0x4/0x8, no gaps after the first.
- InstrReady=0, stream PCs until full (DEPTH=4) -> PCReady=0 after 4 accepts; one pop -> exactly one more PC accepted next cycle.
- 2 requests outstanding at memory latency 5, assert Flush, then PCIn=0x100 -> both stale responses dropped; first InstrValid shows InstrPC=0x100.
- Flush coinciding with MemRspValid and PCValid in the same cycle -> response discarded, PC not accepted, drop count decremented, InstrValid=0 next cycle.
- MemReqReady held low 3 cycles -> MemReqAddr/MemReqValid stable throughout; Rst in the 2nd cycle -> all outputs at reset values the next cycle.
- With FETCH_MISALIGN_CHECK_EN: PCIn=0x6 between 0x0 and 0x8 -> three entries delivered in order, middle one InstrFault=1, InstrPC=0x6, only two memory requests issued.
